klingon_scan_display: RTL and testbench



---
 rtl/klingon_pkg.sv | 32 +++
 rtl/klingon_digit_rom.sv | 32 +++
 rtl/klingon_scan_display.sv | 138 +++++++++++++
 tb/tb_klingon_scan_display.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/klingon_pkg.sv
// ============================================================================
// klingon_pkg : shared glyph constants and sizing helper for the scan display
// Rev 1.0
// ============================================================================
`default_nettype none

package klingon_pkg;

  // Active-high glyphs with bit order Y[6:0] = a,b,c,d,e,f,g (bit 0 is the middle bar)
  localparam logic [6:0] KLINGON_SEG [0:9] = '{
    7'b0011100,
    7'b1000000,
    7'b1000001,
    7'b1001001,
    7'b0110000,
    7'b0110001,
    7'b0111001,
    7'b0110110,
    7'b1110000,
    7'b1111001
  };

  localparam logic [6:0] SEG_ERR = 7'b0000001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/klingon_digit_rom.sv
// ============================================================================
// klingon_digit_rom : 4-bit code to active-high Klingon segment pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module klingon_digit_rom
  import klingon_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (code_i)
      4'd0:    seg_o = KLINGON_SEG[0];
      4'd1:    seg_o = KLINGON_SEG[1];
      4'd2:    seg_o = KLINGON_SEG[2];
      4'd3:    seg_o = KLINGON_SEG[3];
      4'd4:    seg_o = KLINGON_SEG[4];
      4'd5:    seg_o = KLINGON_SEG[5];
      4'd6:    seg_o = KLINGON_SEG[6];
      4'd7:    seg_o = KLINGON_SEG[7];
      4'd8:    seg_o = KLINGON_SEG[8];
      4'd9:    seg_o = KLINGON_SEG[9];
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/klingon_scan_display.sv
// ============================================================================
// klingon_scan_display : time-multiplexed Klingon-numeral 7-segment driver
// Rev 1.0
// ============================================================================
`default_nettype none

module klingon_scan_display
  import klingon_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_sync
);

  localparam int                IDX_W    = idx_width(DIGITS);
  localparam int                CNT_W    = idx_width(REFRESH_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_sync_q, frame_sync_d;

  logic                w_tick;
  logic                w_frame_end;
  logic                w_upper_nz;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_an_onehot;
  logic [3:0]          w_code;
  logic                w_cur_blank;
  logic [6:0]          w_glyph;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_IDLE;
      an_q         <= AN_IDLE;
      frame_sync_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  // Commit and accept are mutually exclusive: one needs pending set, the other clear
  always_comb begin
    w_tick      = (div_cnt_q == CNT_LAST);
    w_frame_end = w_tick && (idx_q == LAST_IDX);
    div_cnt_d   = w_tick ? '0 : div_cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    pend_d    = pend_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (w_frame_end && pending_q) begin
      shadow_d  = pend_q;
      pending_d = 1'b0;
    end else if (load && !pending_q) begin
      pend_d    = value;
      pending_d = 1'b1;
    end
  end

  // Walk from the top digit down; a digit stays dark while everything above it is zero
  always_comb begin
    w_upper_nz = 1'b0;
    w_blank    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_upper_nz = w_upper_nz | (shadow_q[4*k +: 4] != 4'd0);
      w_blank[k] = blank_lz & ~w_upper_nz;
    end
  end

  always_comb begin
    w_code      = 4'd0;
    w_cur_blank = 1'b0;
    w_an_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_code         = shadow_q[4*k +: 4];
        w_cur_blank    = w_blank[k];
        w_an_onehot[k] = 1'b1;
      end
    end
  end

  klingon_digit_rom u_digit_rom (
    .code_i (w_code),
    .seg_o  (w_glyph)
  );

  always_comb begin
    seg_d        = w_cur_blank ? SEG_OFF : w_glyph;
    an_d         = w_cur_blank ? '0 : w_an_onehot;
    frame_sync_d = w_frame_end;
    if (ACTIVE_LOW) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  assign ready      = ~pending_q;
  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_sync = frame_sync_q;

endmodule

`default_nettype wire

// File: tb/tb_klingon_scan_display.sv
// ============================================================================
// tb_klingon_scan_display : randomized bench with a cycle-count reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_klingon_scan_display;

  localparam int D  = 4;
  localparam int RD = 4;

  localparam logic [6:0] GLYPH [0:9] = '{
    7'b0011100, 7'b1000000, 7'b1000001, 7'b1001001, 7'b0110000,
    7'b0110001, 7'b0111001, 7'b0110110, 7'b1110000, 7'b1111001
  };
  localparam logic [6:0] ERR_GLYPH = 7'b0000001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          blank_lz = 1'b0;
  logic          ready;
  logic [6:0]    seg_out;
  logic [D-1:0]  an_out;
  logic          frame_sync;

  int errors = 0;
  int checks = 0;

  // Reference state: cycles since reset released, plus the load/commit registers
  int            m_n = 0;
  logic [15:0]   m_shadow = '0;
  logic [15:0]   m_pend = '0;
  logic          m_pending = 1'b0;

  klingon_scan_display #(
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .ready      (ready),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] c);
    return (c < 4'd10) ? GLYPH[c] : ERR_GLYPH;
  endfunction

  // One clock: predict from pre-edge state and inputs, advance the model, compare after the edge
  task automatic cycle();
    logic [6:0]   e_seg;
    logic [D-1:0] e_an;
    logic         e_fs;
    int           k;
    bit           fe;
    bit           dark;
    if (reset) begin
      e_seg     = 7'h7F;
      e_an      = '1;
      e_fs      = 1'b0;
      m_n       = 0;
      m_shadow  = '0;
      m_pend    = '0;
      m_pending = 1'b0;
    end else begin
      k    = (m_n / RD) % D;
      fe   = ((m_n % (RD * D)) == (RD * D - 1));
      dark = blank_lz && (k >= 1) && ((m_shadow >> (4 * k)) == 16'd0);
      e_seg = dark ? 7'h7F : ~glyph_of(m_shadow[4*k +: 4]);
      e_an  = dark ? '1 : ~(D'(1) << k);
      e_fs  = fe;
      if (fe && m_pending) begin
        m_shadow  = m_pend;
        m_pending = 1'b0;
      end else if (load && !m_pending) begin
        m_pend    = value;
        m_pending = 1'b1;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    check_val("seg_out",    32'(seg_out),    32'(e_seg));
    check_val("an_out",     32'(an_out),     32'(e_an));
    check_val("frame_sync", 32'(frame_sync), 32'(e_fs));
    check_val("ready",      32'(ready),      32'(!m_pending));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_once(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run(3);
    reset = 1'b0;

    run(5);
    load_once(16'h1234);
    run(3);
    load_once(16'h9999);
    run(40);

    blank_lz = 1'b1;
    load_once(16'h0070);
    run(40);
    blank_lz = 1'b0;
    run(20);

    load_once(16'h00A5);
    blank_lz = 1'b1;
    run(40);
    blank_lz = 1'b0;
    run(20);

    run(6);
    load_once(16'h5555);
    run(3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(40);

    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    load  = 1'b0;
    reset = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
